mem_arbiter: RTL

Shares one single-ported, fixed-latency unified memory between the fetch stage (I-side, read-only) and the memory stage (D-side, load/store).
- Sits between fetch/memory stages and the memory array inside the processor top level.
- Accepts level requests and runs one access at a time.
- Drives stall signals back to the pipeline.
- Returns a one-cycle done pulse with registered read data.

---
 rtl/mem_arbiter_pkg.sv | 19 +
 rtl/mem_arbiter_lat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encoding and default sizes shared by the
// I/D memory arbiter and the fetch/memory stages around it.
package mem_arbiter_pkg;

    localparam int DEF_MEM_LAT = 2;
    localparam int DEF_AW      = 16;
    localparam int DEF_DW      = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GNT_I = 2'b01,
        ST_GNT_D = 2'b10
    } arbState_t;

    function automatic int cntWidth(input int lat);
        return $clog2(lat) + 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_lat_counter.sv
// mem_lat_counter: loadable down-counter with zero flag that times
// one memory access. Ports: load/loadVal, dec, cnt, zero.
module mem_lat_counter
    import mem_arbiter_pkg::*;
#(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] loadVal,
    input  logic         dec,
    output logic [W-1:0] cnt,
    output logic         zero
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= loadVal;
        end else if (dec && !zero) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one fixed-latency memory between fetch (read)
// and memory stage (load/store); i_*/d_* requester ports, m_* memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = DEF_MEM_LAT,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic          i_stall,
    input  logic          d_rd,
    input  logic          d_wr,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    output logic          d_stall,
    output logic          err,
    output logic          m_en,
    output logic          m_wr,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata
);

    localparam int CW = cntWidth(MEM_LAT);
    localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    arbState_t     state;
    logic          lastD;
    logic          opWr;
    logic [CW-1:0] cnt;
    logic          cntZero;
    logic          iElig;
    logic          dElig;
    logic          grantI;
    logic          grantD;
    logic          load;
    logic          dec;
    logic          newWr;

    // a side whose done pulse is up this cycle is not re-granted
    assign iElig = i_req & ~i_done;
    assign dElig = (d_rd | d_wr) & ~d_done;

    // round robin: D wins a tie unless D had the last grant
    assign grantD = dElig & (~iElig | ~lastD);
    assign grantI = iElig & ~grantD;

    assign i_stall = iElig;
    assign d_stall = dElig;

    assign load  = (state == ST_IDLE) & (grantI | grantD);
    assign dec   = (state != ST_IDLE);
    assign newWr = grantD & d_wr & ~d_rd;

    mem_lat_counter #(
        .W(CW)
    ) uLatCnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .loadVal(CNT_LOAD),
        .dec    (dec),
        .cnt    (cnt),
        .zero   (cntZero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            lastD   <= 1'b0;
            opWr    <= 1'b0;
            err     <= 1'b0;
            i_done  <= 1'b0;
            d_done  <= 1'b0;
            i_rdata <= '0;
            d_rdata <= '0;
            m_en    <= 1'b0;
            m_wr    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            m_wr   <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (load) begin
                        state <= grantD ? ST_GNT_D : ST_GNT_I;
                        lastD <= grantD;
                        opWr  <= newWr;
                        m_en  <= 1'b1;
                        // single-cycle access strobes immediately
                        m_wr  <= newWr & (CNT_LOAD == '0);
                        if (grantD) begin
                            m_addr  <= d_addr;
                            m_wdata <= d_wdata;
                            err     <= err | (d_rd & d_wr);
                        end else begin
                            m_addr <= i_addr;
                        end
                    end
                end
                ST_GNT_I, ST_GNT_D: begin
                    if (cntZero) begin
                        state <= ST_IDLE;
                        m_en  <= 1'b0;
                        if (state == ST_GNT_I) begin
                            i_done  <= 1'b1;
                            i_rdata <= m_rdata;
                        end else begin
                            d_done <= 1'b1;
                            if (!opWr) begin
                                d_rdata <= m_rdata;
                            end
                        end
                    end else begin
                        // strobe lands on the final access cycle
                        m_wr <= opWr & (cnt == CNT_ONE);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
